// File: rtl/spi_master_ctrl_pkg.sv
// Shared encodings for the SPI master transaction sequencer: frame widths,
// read/write encoding and FSM state type. Optional macro: SPI_CTRL_CSGAP_EN.
package spi_master_ctrl_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned HDR_W  = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ADDR   = 3'd2,
    TURN   = 3'd3,
    DATA   = 3'd4,
    FINISH = 3'd5,
    GAP    = 3'd6
  } state_t;

  function automatic logic [HDR_W-1:0] make_header(input logic [ADDR_W-1:0] addr,
                                                   input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/spi_master_ctrl_sclk_gen.sv
// SPI serial clock generator: half-period counter, sclk and rise/fall strobes.
// The first half-period after enable is a low lead-in (the SETUP phase).
module spi_sclk_gen #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(CLKDIV + 1);

  logic [CW-1:0] cnt;
  logic          lead;

  assign tick = en && (cnt == CW'(CLKDIV - 1));
  assign rise = tick && !lead && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
      lead <= 1'b1;
    end else if (tick) begin
      cnt  <= '0;
      lead <= 1'b0;
      if (!lead) sclk <= ~sclk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transaction sequencer: serialises {addr, rw}, turnaround and a
// data byte onto cs/sclk/mosi. Optional macro SPI_CTRL_CSGAP_EN adds a cs-high GAP.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned CLKDIV    = 2,
  parameter int unsigned TURN_BITS = 2,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned CW        = $clog2(CLKDIV + 1);
  localparam logic [3:0]  TURN_LAST = 4'((TURN_BITS == 0) ? 0 : TURN_BITS - 1);

  state_t             state, state_next;
  logic [3:0]         bit_cnt, bit_cnt_next;
  logic [CW-1:0]      fin_cnt, fin_cnt_next;
  logic [HDR_W-1:0]   tx, tx_next, hdr_in;
  logic [DATA_W-1:0]  cap, cap_next, wdata_q, wdata_q_next, rdata_next, tx_data;
  logic               rw_q, rw_q_next, cs_next, mosi_next, done_next;
  logic               sclk_en, tick, rise, fall;
`ifdef SPI_CTRL_CSGAP_EN
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  logic [GW-1:0]      gap_cnt, gap_cnt_next;
`endif

  assign ready   = (state == IDLE);
  assign sclk_en = (state == SETUP) || (state == ADDR) || (state == TURN) || (state == DATA);
  assign hdr_in  = make_header(addr, rw);
  assign tx_data = (rw_q == RW_WRITE) ? wdata_q : '0;

  spi_sclk_gen #(.CLKDIV(CLKDIV)) u_sclk_gen (
    .clk  (clk),
    .reset(reset),
    .en   (sclk_en),
    .sclk (sclk),
    .tick (tick),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    fin_cnt_next = fin_cnt;
    tx_next      = tx;
    cap_next     = cap;
    wdata_q_next = wdata_q;
    rw_q_next    = rw_q;
    cs_next      = cs;
    mosi_next    = mosi;
    done_next    = 1'b0;
    rdata_next   = rdata;
`ifdef SPI_CTRL_CSGAP_EN
    gap_cnt_next = gap_cnt;
`endif
    case (state)
      IDLE: begin
        cs_next   = 1'b1;
        mosi_next = 1'b0;
        if (req) begin
          rw_q_next    = rw;
          wdata_q_next = wdata;
          tx_next      = hdr_in;
          mosi_next    = hdr_in[HDR_W-1];
          cs_next      = 1'b0;
          bit_cnt_next = '0;
          state_next   = SETUP;
        end
      end
      SETUP: if (tick) state_next = ADDR;
      ADDR: if (fall) begin
        if (bit_cnt == 4'd7) begin
          bit_cnt_next = '0;
          if (TURN_BITS == 0) begin
            state_next = DATA;
            tx_next    = tx_data;
            mosi_next  = tx_data[DATA_W-1];
          end else begin
            state_next = TURN;
            mosi_next  = 1'b0;
          end
        end else begin
          bit_cnt_next = bit_cnt + 4'd1;
          tx_next      = tx << 1;
          mosi_next    = tx[HDR_W-2];
        end
      end
      TURN: if (fall) begin
        if (bit_cnt == TURN_LAST) begin
          bit_cnt_next = '0;
          state_next   = DATA;
          tx_next      = tx_data;
          mosi_next    = tx_data[DATA_W-1];
        end else begin
          bit_cnt_next = bit_cnt + 4'd1;
        end
      end
      DATA: begin
        if (rise && (rw_q == RW_READ)) cap_next = {cap[DATA_W-2:0], miso};
        if (fall) begin
          if (bit_cnt == 4'd7) begin
            bit_cnt_next = '0;
            fin_cnt_next = '0;
            mosi_next    = 1'b0;
            state_next   = FINISH;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
            tx_next      = tx << 1;
            mosi_next    = tx[HDR_W-2];
          end
        end
      end
      FINISH: begin
        if (fin_cnt == CW'(CLKDIV - 1)) begin
          cs_next   = 1'b1;
          done_next = 1'b1;
          if (rw_q == RW_READ) rdata_next = cap;
`ifdef SPI_CTRL_CSGAP_EN
          gap_cnt_next = '0;
          state_next   = (CS_GAP == 0) ? IDLE : GAP;
`else
          state_next   = IDLE;
`endif
        end else begin
          fin_cnt_next = fin_cnt + CW'(1);
        end
      end
`ifdef SPI_CTRL_CSGAP_EN
      GAP: begin
        if (gap_cnt == GW'(CS_GAP - 1)) state_next = IDLE;
        else                            gap_cnt_next = gap_cnt + GW'(1);
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      fin_cnt <= '0;
      tx      <= '0;
      cap     <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
`ifdef SPI_CTRL_CSGAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      fin_cnt <= fin_cnt_next;
      tx      <= tx_next;
      cap     <= cap_next;
      wdata_q <= wdata_q_next;
      rw_q    <= rw_q_next;
      cs      <= cs_next;
      mosi    <= mosi_next;
      done    <= done_next;
      rdata   <= rdata_next;
`ifdef SPI_CTRL_CSGAP_EN
      gap_cnt <= gap_cnt_next;
`endif
    end
  end

endmodule
